voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter INC_SCALE, default 89478, meaning the phase-increment multiplier, round(2^32/48000).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port sample_tick, input, 1: a one-cycle strobe that requests one output sample.
REQ-005 SHALL have port frequencies[7:0], input, 8x32 signed: per-voice frequency in Hz, Q12.20.
REQ-006 SHALL have port voice_volumes[7:0], input, 8x32 signed: per-voice gain, Q12.20, where 1<<20 is unity.
REQ-007 SHALL have port wave_sel, input, 1: 0 selects sawtooth, 1 selects square.
REQ-008 SHALL have port sample, output, 16 signed: the mixed audio sample.
REQ-009 SHALL have port sample_valid, output, 1: a one-cycle strobe marking a new sample.
REQ-010 SHALL have port busy, output, 1: high while a tick is being processed.
REQ-011 SHALL have port overrun, output, 1: a sticky flag set when a tick is lost.

Function
REQ-012 SHALL implement FSM IDLE -> ACCUM -> OUTPUT -> IDLE.
- sample_tick in IDLE: go to ACCUM; clear voice index v and accumulator acc.
REQ-013 SHALL process one voice per cycle in ACCUM, v = 0..7 in order, sampling frequencies[v], voice_volumes[v] and wave_sel in that cycle; after v=7, go to OUTPUT.
REQ-014 SHALL compute inc = (frequencies[v] * INC_SCALE) >> 20.
- 64-bit product; truncate the result to 32 bits.
- A negative frequency gives inc = 0.
REQ-015 SHALL hold a 32-bit phase[v] per voice.
- Volume > 0: phase[v] += inc, wrapping modulo 2^32.
- Volume <= 0: phase[v] is forced to 0.
REQ-016 SHALL form wave, 16-bit signed, from the updated phase.
- Saw: wave = phase[31:16] - 32768.
- Square: wave = +32767 if phase[31] = 0, else -32768.
REQ-017 SHALL clamp gain: vol <= 0 gives g = 0; vol > 1<<20 gives g = 1<<20; otherwise g = vol.
REQ-018 SHALL compute scaled = (wave * g) >>> 20 (signed, arithmetic) and add it to acc, 19-bit signed.
- Overflow is impossible by construction; no saturation logic.
REQ-019 SHALL, in OUTPUT, register sample = acc >>> 3 (floor), pulse sample_valid for 1 cycle and return to IDLE.
REQ-020 SHALL have a latency of exactly 10 cycles:
- sample_tick sampled in IDLE at edge N; sample_valid high in the cycle after edge N+10.
REQ-021 SHALL hold sample between updates.
REQ-022 SHALL drive busy high in ACCUM and OUTPUT.
REQ-023 SHALL ignore sample_tick while busy and set overrun = 1; overrun stays set until reset.
REQ-024 SHALL give sample_tick in the OUTPUT cycle the same treatment as REQ-023: ignored, overrun set.
REQ-025 SHALL never modify phase while in IDLE.

Reset
REQ-026 SHALL, on reset_n low, immediately force the following, including mid-ACCUM:
- FSM = IDLE, v = 0, acc = 0;
- all phase = 0;
- sample = 0, sample_valid = 0, busy = 0, overrun = 0.
REQ-027 SHALL abandon a partially accumulated sample on reset and never emit it.
REQ-028 SHALL accept a tick on the first rising edge after reset_n deasserts.

Verification
REQ-029 Saw, voice 0 only: freq 55<<20, vol 1<<20, others vol 0, one tick -> after 10 cycles phase[0] = 4921290 and sample = -4087, valid for one cycle.
REQ-030 Square, all 8 voices at vol 1<<20, freq 55<<20, one tick -> sample = 32767; after phase[31] sets, sample = -32768.
REQ-031 Gain clamp: voice 0 square, vol 3<<20 -> sample = 4095 (same as vol 1<<20); vol -5 -> sample = 0 and phase[0] = 0.
REQ-032 Overrun: tick, then a second tick 4 cycles later -> exactly one sample_valid, overrun = 1 and held; busy high for 9 cycles.
REQ-033 Reset mid-ACCUM (v=4) -> no sample_valid, all outputs 0; a following tick yields the same result as a fresh start.
REQ-034 Wrap: freq 330<<20, vol 1<<20, 1000 ticks -> phase[0] equals 1000*29527740 mod 2^32; compare against a reference model every sample.

Source files
------------

// File: rtl/voice_mixer.sv
// Eight-voice sawtooth/square oscillator mixer: one voice per cycle is accumulated after each
// sample_tick, and the mixed 16-bit sample is emitted 10 cycles after the tick.
module voice_mixer #(
    parameter logic [31:0] INC_SCALE = 32'd89478
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_tick,
    input  logic signed [31:0] frequencies [8],
    input  logic signed [31:0] voice_volumes [8],
    input  logic               wave_sel,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         v;
    logic signed [18:0] acc;
    logic signed [18:0] scaled_q;
    logic signed [18:0] scaled;
    logic [31:0]        phase [8];
    logic               out_pending;
    logic signed [31:0] freq_v;
    logic signed [31:0] vol_v;
    logic [31:0]        inc;
    logic [31:0]        phase_new;
    logic signed [15:0] wave;
    logic [20:0]        gain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = ACCUM;
            ACCUM:   if (v == 3'd7) state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Per-voice oscillator step, gain clamp and scaling for the voice currently indexed by v.
    always_comb begin
        freq_v    = frequencies[v];
        vol_v     = voice_volumes[v];
        inc       = '0;
        phase_new = '0;
        wave      = '0;
        gain      = '0;
        if (!freq_v[31]) begin
            inc = 32'((64'(unsigned'(freq_v)) * 64'(INC_SCALE)) >> 20);
        end
        if (vol_v > 32'sd0) begin
            phase_new = phase[v] + inc;
        end
        if (wave_sel) begin
            wave = phase_new[31] ? 16'sh8000 : 16'sh7fff;
        end else begin
            wave = {~phase_new[31], phase_new[30:16]};
        end
        if (vol_v <= 32'sd0) begin
            gain = '0;
        end else if (vol_v > 32'sh0010_0000) begin
            gain = 21'h10_0000;
        end else begin
            gain = vol_v[20:0];
        end
        scaled = 19'((37'(wave) * 37'($signed({1'b0, gain}))) >>> 20);
    end

    // The scaled product is registered before accumulation, so the last voice lands in acc
    // during OUTPUT and the sample is published one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v            <= '0;
            acc          <= '0;
            scaled_q     <= '0;
            out_pending  <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                phase[i] <= '0;
            end
        end else begin
            sample_valid <= out_pending;
            out_pending  <= 1'b0;
            if (out_pending) begin
                sample <= 16'(acc >>> 3);
            end
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        v        <= '0;
                        acc      <= '0;
                        scaled_q <= '0;
                    end
                end
                ACCUM: begin
                    phase[v] <= phase_new;
                    scaled_q <= scaled;
                    acc      <= acc + scaled_q;
                    v        <= v + 3'd1;
                end
                OUTPUT: begin
                    acc         <= acc + scaled_q;
                    out_pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed and random ticks compared against an arithmetic model
// of the oscillators and mix.
module tb_voice_mixer;

    localparam longint INC      = 89478;
    localparam longint TWO32    = 64'd4294967296;
    localparam longint UNITY    = 1048576;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic signed [31:0] frequencies [8];
    logic signed [31:0] voice_volumes [8];
    logic               wave_sel = 1'b0;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    int errors = 0;
    int checks = 0;

    longint mphase [8];
    longint model_sample;

    voice_mixer #(.INC_SCALE(32'd89478)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .wave_sel      (wave_sel),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // One output sample computed from the current inputs; advances the model phases.
    function automatic void modelTick();
        longint f, vol, inc, wave, g, acc;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            f   = frequencies[k];
            vol = voice_volumes[k];
            inc = (f < 0) ? 0 : ((f * INC) / UNITY) % TWO32;
            mphase[k] = (vol > 0) ? (mphase[k] + inc) % TWO32 : 0;
            if (wave_sel) wave = (mphase[k] < TWO32 / 2) ? 32767 : -32768;
            else          wave = (mphase[k] / 65536) - 32768;
            if (vol <= 0)          g = 0;
            else if (vol > UNITY)  g = UNITY;
            else                   g = vol;
            acc = acc + floorDiv(wave * g, UNITY);
        end
        model_sample = floorDiv(acc, 8);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 8; k++) mphase[k] = 0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic setVoice0(input logic signed [31:0] freq, input logic signed [31:0] vol,
                             input logic sel);
        for (int k = 0; k < 8; k++) begin
            frequencies[k]   = 32'sd0;
            voice_volumes[k] = 32'sd0;
        end
        frequencies[0]   = freq;
        voice_volumes[0] = vol;
        wave_sel         = sel;
    endtask

    // Called at a falling edge; issues one tick, optionally a second one extra_at cycles on.
    task automatic applyStimulus(input string tag, input int extra_at, input logic exp_overrun);
        int                 busy_cnt;
        int                 valid_cnt;
        int                 valid_idx;
        logic signed [15:0] held;
        busy_cnt  = 0;
        valid_cnt = 0;
        valid_idx = -1;
        held      = 'x;
        modelTick();
        sample_tick = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sample_tick = (i == extra_at);
            if (busy) busy_cnt++;
            if (sample_valid) begin
                valid_cnt++;
                valid_idx = i;
                held      = sample;
            end
            @(negedge clk);
        end
        sample_tick = 1'b0;
        checkOutput({tag, "_valid_count"}, valid_cnt, 1);
        checkOutput({tag, "_latency"}, valid_idx, 10);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, 9);
        checkOutput({tag, "_sample"}, held, model_sample);
        checkOutput({tag, "_sample_held"}, sample, model_sample);
        checkOutput({tag, "_overrun"}, {63'd0, overrun}, {63'd0, exp_overrun});
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_phase%0d", tag, k), {32'd0, dut.phase[k]}, mphase[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            frequencies[k]   = 32'sd0;
            voice_volumes[k] = 32'sd0;
        end
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_sample", sample, 0);
        checkOutput("rst_valid", {63'd0, sample_valid}, 0);
        checkOutput("rst_busy", {63'd0, busy}, 0);
        checkOutput("rst_overrun", {63'd0, overrun}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] saw voice 0 at 55 Hz");
        setVoice0(32'sd55 <<< 20, 32'sd1 <<< 20, 1'b0);
        applyStimulus("saw55", -1, 1'b0);
        checkOutput("saw55_const_sample", sample, -4087);
        checkOutput("saw55_const_phase", {32'd0, dut.phase[0]}, 4921290);

        $display("[TB] gain clamp");
        setVoice0(32'sd55 <<< 20, 32'sd3 <<< 20, 1'b1);
        applyStimulus("clamp_hi", -1, 1'b0);
        checkOutput("clamp_hi_const", sample, 4095);
        setVoice0(32'sd55 <<< 20, -32'sd5, 1'b1);
        applyStimulus("clamp_neg", -1, 1'b0);
        checkOutput("clamp_neg_const", sample, 0);
        checkOutput("clamp_neg_phase", {32'd0, dut.phase[0]}, 0);

        $display("[TB] overrun");
        setVoice0(32'sd55 <<< 20, 32'sd1 <<< 20, 1'b0);
        applyStimulus("ovr", 3, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("ovr_sticky", {63'd0, overrun}, 1);

        $display("[TB] reset mid-accumulation");
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_busy", {63'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_sample", sample, 0);
        checkOutput("mid_rst_valid", {63'd0, sample_valid}, 0);
        checkOutput("mid_rst_busy", {63'd0, busy}, 0);
        checkOutput("mid_rst_overrun", {63'd0, overrun}, 0);
        checkOutput("mid_rst_phase0", {32'd0, dut.phase[0]}, 0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("post_rst", -1, 1'b0);
        checkOutput("post_rst_const", sample, -4087);

        $display("[TB] square, all voices");
        doReset();
        for (int k = 0; k < 8; k++) begin
            frequencies[k]   = 32'sd55 <<< 20;
            voice_volumes[k] = 32'sd1 <<< 20;
        end
        wave_sel = 1'b1;
        for (int t = 1; t <= 440; t++) begin
            applyStimulus("sq8", -1, 1'b0);
            if (t == 1)   checkOutput("sq8_first", sample, 32767);
            if (t == 436) checkOutput("sq8_last_high", sample, 32767);
            if (t == 437) checkOutput("sq8_first_low", sample, -32768);
        end

        $display("[TB] random voices");
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 8; k++) begin
                frequencies[k]   = $urandom;
                voice_volumes[k] = 32'($urandom_range(0, 3 * 1048576)) - 32'sd1048576;
            end
            wave_sel = 1'($urandom_range(0, 1));
            applyStimulus("rand", -1, 1'b0);
        end

        $display("[TB] phase wrap at 330 Hz");
        doReset();
        setVoice0(32'sd330 <<< 20, 32'sd1 <<< 20, 1'b0);
        for (int t = 0; t < 1000; t++) begin
            applyStimulus("wrap", -1, 1'b0);
        end
        checkOutput("wrap_phase_total", {32'd0, dut.phase[0]}, (1000 * 29527740) % TWO32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
